// File: rtl/hazard_pkg.sv
// Shared types for the hazard scoreboard: FSM state, pipeline control bundle,
// load-latency limits and perf-counter width.
package hazard_pkg;

    localparam int unsigned LOAD_LAT_MIN = 1;
    localparam int unsigned LOAD_LAT_MAX = 8;
    localparam int unsigned PERF_W       = 32;

    // Reason for the pipeline action taken in a cycle
    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MDU_STALL  = 2'd2,
        ST_FLUSH      = 2'd3
    } hz_state_e;

    // Pipeline control bundle driven towards IF/ID/EX
    typedef struct packed {
        logic pc_write_en;
        logic if_id_write_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic stall;
    } pipe_ctrl_t;

    // Decode an action reason into the pipeline control bundle
    function automatic pipe_ctrl_t ctrl_for(hz_state_e st);
        pipe_ctrl_t c;
        c.pc_write_en    = 1'b1;
        c.if_id_write_en = 1'b1;
        c.if_id_flush    = 1'b0;
        c.id_ex_flush    = 1'b0;
        c.stall          = 1'b0;
        case (st)
            ST_FLUSH: begin
                c.if_id_flush = 1'b1;
                c.id_ex_flush = 1'b1;
            end
            ST_LOAD_STALL, ST_MDU_STALL: begin
                c.pc_write_en    = 1'b0;
                c.if_id_write_en = 1'b0;
                c.id_ex_flush    = 1'b1;
                c.stall          = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pending_ctr.sv
// Per-register load-pending counter: loads on set, otherwise counts down to zero.
module pending_ctr
    import hazard_pkg::*;
#(
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned SET_VAL = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             set_i,
    output logic [CNT_W-1:0] cnt_o
);

    // Set has priority over the free-running decrement
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_o <= '0;
        end else if (set_i) begin
            cnt_o <= CNT_W'(SET_VAL);
        end else if (cnt_o != '0) begin
            cnt_o <= cnt_o - CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use / MUL-DIV hazard scoreboard and pipeline control for an in-order core.
// Optional feature macro: HAZARD_PERF_EN adds saturating stall/flush counters.
// LOAD_LAT must lie within hazard_pkg::LOAD_LAT_MIN..LOAD_LAT_MAX.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter  int unsigned LOAD_LAT   = 2,
    parameter  int unsigned NUM_REGS   = 32,
    localparam int unsigned REG_ADDR_W = $clog2(NUM_REGS)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] rs1_addr_id_i,
    input  logic [REG_ADDR_W-1:0] rs2_addr_id_i,
    input  logic                  rs1_used_id_i,
    input  logic                  rs2_used_id_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_id_i,
    input  logic                  id_is_load_i,
    input  logic                  id_is_mdu_i,
    input  logic                  mdu_done_i,
    input  logic                  flush_req_i,
    output logic                  pc_write_en_o,
    output logic                  if_id_write_en_o,
    output logic                  if_id_flush_o,
    output logic                  id_ex_flush_o,
    output logic                  stall_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0]     load_stall_cnt_o,
    output logic [PERF_W-1:0]     mdu_stall_cnt_o,
    output logic [PERF_W-1:0]     flush_cnt_o
`endif
);

    localparam int unsigned CNT_W   = $clog2(LOAD_LAT + 1);
    localparam int unsigned SET_VAL = LOAD_LAT - 1;

    logic [CNT_W-1:0]      cnt [NUM_REGS];
    logic                  issue;
    logic                  rs1_pend;
    logic                  rs2_pend;
    logic                  rs1_mdu;
    logic                  rs2_mdu;
    logic                  load_hz;
    logic                  mdu_hz;
    logic                  mdu_busy_q;
    logic [REG_ADDR_W-1:0] mdu_rd_q;
    hz_state_e             state_q;
    hz_state_e             state_d;
    pipe_ctrl_t            ctrl;

    // x0 is hard-wired and never pending
    assign cnt[0] = '0;

    // One pending counter per writable register
    for (genvar r = 1; r < NUM_REGS; r++) begin : g_pend
        logic set;
        assign set = issue & id_is_load_i & (rd_addr_id_i == REG_ADDR_W'(r));
        pending_ctr #(
            .CNT_W  (CNT_W),
            .SET_VAL(SET_VAL)
        ) u_ctr (
            .clk_i (clk_i),
            .rst_ni(rst_ni),
            .set_i (set),
            .cnt_o (cnt[r])
        );
    end

    // Hazard detection against pending loads and the in-flight MDU op
    always_comb begin
        rs1_pend = rs1_used_id_i && (rs1_addr_id_i != '0) && (cnt[rs1_addr_id_i] != '0);
        rs2_pend = rs2_used_id_i && (rs2_addr_id_i != '0) && (cnt[rs2_addr_id_i] != '0);
        rs1_mdu  = rs1_used_id_i && (mdu_rd_q != '0) && (rs1_addr_id_i == mdu_rd_q);
        rs2_mdu  = rs2_used_id_i && (mdu_rd_q != '0) && (rs2_addr_id_i == mdu_rd_q);
        load_hz  = id_valid_i && (rs1_pend || rs2_pend);
        mdu_hz   = id_valid_i && mdu_busy_q && (id_is_mdu_i || rs1_mdu || rs2_mdu);
    end

    // Next action: flush beats MDU hazard beats load hazard
    always_comb begin
        state_d = ST_RUN;
        if (flush_req_i) begin
            state_d = ST_FLUSH;
        end else if (mdu_hz) begin
            state_d = ST_MDU_STALL;
        end else if (load_hz) begin
            state_d = ST_LOAD_STALL;
        end
    end

    assign ctrl             = ctrl_for(state_d);
    assign pc_write_en_o    = ctrl.pc_write_en;
    assign if_id_write_en_o = ctrl.if_id_write_en;
    assign if_id_flush_o    = ctrl.if_id_flush;
    assign id_ex_flush_o    = ctrl.id_ex_flush;
    assign stall_o          = ctrl.stall;
    assign issue            = id_valid_i & ~ctrl.stall & ~flush_req_i;

    // Track the single outstanding MDU op; a done pulse with nothing busy is a no-op
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mdu_busy_q <= 1'b0;
            mdu_rd_q   <= '0;
        end else if (issue && id_is_mdu_i) begin
            mdu_busy_q <= 1'b1;
            mdu_rd_q   <= rd_addr_id_i;
        end else if (mdu_done_i) begin
            mdu_busy_q <= 1'b0;
        end
    end

    // Registered reason for the previous cycle's action (debug visibility)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // The debug state register must always hold a defined encoding
    always_comb begin
        assert (state_q inside {ST_RUN, ST_LOAD_STALL, ST_MDU_STALL, ST_FLUSH});
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] load_stall_cnt_q;
    logic [PERF_W-1:0] mdu_stall_cnt_q;
    logic [PERF_W-1:0] flush_cnt_q;

    // Saturating tallies of cycles spent in each non-run action
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            load_stall_cnt_q <= '0;
            mdu_stall_cnt_q  <= '0;
            flush_cnt_q      <= '0;
        end else begin
            if ((state_d == ST_LOAD_STALL) && (load_stall_cnt_q != '1)) begin
                load_stall_cnt_q <= load_stall_cnt_q + PERF_W'(1);
            end
            if ((state_d == ST_MDU_STALL) && (mdu_stall_cnt_q != '1)) begin
                mdu_stall_cnt_q <= mdu_stall_cnt_q + PERF_W'(1);
            end
            if ((state_d == ST_FLUSH) && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + PERF_W'(1);
            end
        end
    end

    assign load_stall_cnt_o = load_stall_cnt_q;
    assign mdu_stall_cnt_o  = mdu_stall_cnt_q;
    assign flush_cnt_o      = flush_cnt_q;
`endif

endmodule
